sirv_axi_sram_slv: RTL and testbench

SIRV_AXI_SRAM_SLV -- requirements
Module: sirv_axi_sram_slv

---
 rtl/sirv_axi_sram_slv.sv | 187 ++++++++++++++++++
 tb/tb_sirv_axi_sram_slv.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_axi_sram_slv.sv
// Single-ported AXI4 SRAM slave, round-robin AR/AW arbitration.
// One transaction in flight; FIXED/INCR bursts, no wrap at the end.
module sirv_axi_sram_slv #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic [1:0]      axi_bresp,
  input  logic            axi_arvalid,
  output logic            axi_arready,
  input  logic [AW-1:0]   axi_araddr,
  input  logic [7:0]      axi_arlen,
  input  logic [1:0]      axi_arburst,
  output logic            axi_rvalid,
  input  logic            axi_rready,
  output logic [DW-1:0]   axi_rdata,
  output logic [1:0]      axi_rresp,
  output logic            axi_rlast
);

  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * NB);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    WRESP
  } state_t;

  state_t state_q, state_d;

  logic          last_w_q;
  logic [7:0]    len_q;
  logic [1:0]    burst_q;
  logic [7:0]    beat_q;
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;
  logic          rlast_q;
  logic [1:0]    bresp_q;

  logic [DW-1:0] mem [DEPTH];

  function automatic logic oor(input logic [AW-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  function automatic logic [IW-1:0] widx(input logic [AW-1:0] a);
    return a[OFS+IW-1:OFS];
  endfunction

  logic idle, grant_w, grant_r;
  logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic cur_last, w_err;
  logic [AW-1:0] nxt_addr, rd_addr;
  logic [DW-1:0] rd_word;
  logic [1:0]    rd_resp;

  // last_w_q low means a write wins the next tie
  assign idle    = (state_q == IDLE);
  assign grant_w = axi_awvalid & (~axi_arvalid | ~last_w_q);
  assign grant_r = axi_arvalid & (~axi_awvalid | last_w_q);

  assign axi_awready = idle & grant_w & rst_n;
  assign axi_arready = idle & grant_r & rst_n;
  assign axi_wready  = (state_q == WR);
  assign axi_rvalid  = (state_q == RD);
  assign axi_bvalid  = (state_q == WRESP);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q & axi_rvalid;
  assign axi_bresp   = bresp_q;

  assign aw_hs = axi_awvalid & axi_awready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign r_hs  = axi_rvalid & axi_rready;
  assign b_hs  = axi_bvalid & axi_bready;

  assign cur_last = (beat_q == len_q);
  assign nxt_addr = (burst_q == 2'b00) ?
                    addr_q : addr_q + AW'(NB);
  assign rd_addr  = ar_hs ? axi_araddr : nxt_addr;
  assign rd_word  = oor(rd_addr) ? '0 : mem[widx(rd_addr)];
  assign rd_resp  = oor(rd_addr) ? SLVERR : OKAY;
  assign w_err    = err_q | oor(addr_q) |
                    (axi_wlast != cur_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WR;
        else if (ar_hs) state_d = RD;
      end
      RD:    if (r_hs && cur_last) state_d = IDLE;
      WR:    if (w_hs && cur_last) state_d = WRESP;
      WRESP: if (b_hs)             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_w_q <= 1'b0;
      len_q    <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      rlast_q  <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      if (aw_hs) begin
        last_w_q <= 1'b1;
        addr_q   <= axi_awaddr;
        len_q    <= axi_awlen;
        burst_q  <= axi_awburst;
        beat_q   <= '0;
        err_q    <= 1'b0;
      end
      if (ar_hs) begin
        last_w_q <= 1'b0;
        addr_q   <= axi_araddr;
        len_q    <= axi_arlen;
        burst_q  <= axi_arburst;
        beat_q   <= '0;
        rdata_q  <= rd_word;
        rresp_q  <= rd_resp;
        rlast_q  <= (axi_arlen == 8'd0);
      end
      if (r_hs && !cur_last) begin
        addr_q  <= nxt_addr;
        beat_q  <= beat_q + 8'd1;
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
        rlast_q <= (beat_q + 8'd1 == len_q);
      end
      if (w_hs) begin
        err_q <= w_err;
        if (cur_last) begin
          bresp_q <= w_err ? SLVERR : OKAY;
        end else begin
          addr_q <= nxt_addr;
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  // storage is never reset
  always_ff @(posedge clk) begin
    if (w_hs && !oor(addr_q)) begin
      for (int i = 0; i < NB; i++) begin
        if (axi_wstrb[i])
          mem[widx(addr_q)][i*8 +: 8] <= axi_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sirv_axi_sram_slv.sv
// Self-checking bench for sirv_axi_sram_slv.
// Randomized traffic against a word-array reference memory.
module tb_sirv_axi_sram_slv;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;

  sirv_axi_sram_slv #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_m [64];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_d [256];
  logic [1:0]  rd_r [256];
  logic        rd_l [256];
  int          rd_beats, rd_stall_bad;
  logic        rd_first_ok, rd_after_valid;
  logic [1:0]  b_resp;
  int          w_beats, b_hold_bad;
  logic        w_extra_rdy;

  function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                            input logic [1:0] bu,
                                            input int i);
    if (bu == 2'b00) return a;
    return a + 32'(4 * i);
  endfunction

  function automatic logic [33:0] exp_rd(input logic [31:0] a);
    if (a < 32'd256) return {2'b00, mem_m[a[7:2]]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [1:0] exp_b(input logic [31:0] a,
                                       input int len,
                                       input logic [1:0] bu,
                                       input int early);
    logic bad;
    bad = (early >= 0) && (early != len);
    for (int i = 0; i <= len; i++)
      if (beat_addr(a, bu, i) >= 32'd256) bad = 1'b1;
    return bad ? 2'b10 : 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [1:0] bu, input int early,
                          input bit hold);
    int n, d;
    logic [31:0] a;
    axi_awaddr = addr;
    axi_awlen = 8'(len);
    axi_awburst = bu;
    axi_awvalid = 1'b1;
    n = 0;
    #1;
    while (!axi_awready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!axi_awready) begin
      tests_run++; tests_failed++;
      $display("FAIL aw_timeout: awready=0 required 1");
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) axi_awvalid = 1'b0;
    w_beats = 0;
    for (int i = 0; i <= len; i++) begin
      axi_wvalid = 1'b1;
      axi_wdata = wd[i];
      axi_wstrb = ws[i];
      axi_wlast = (early >= 0) ? (i == early) : (i == len);
      n = 0;
      #1;
      while (!axi_wready && n < 200) begin
        @(negedge clk); #1; n++;
      end
      if (axi_wready) begin
        a = beat_addr(addr, bu, i);
        if (a < 32'd256)
          for (int b = 0; b < 4; b++)
            if (ws[i][b]) mem_m[a[7:2]][b*8 +: 8] = wd[i][b*8 +: 8];
        w_beats++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    w_extra_rdy = axi_wready;
    axi_wvalid = 1'b0;
    axi_wlast = 1'b0;
    n = 0;
    while (!axi_bvalid && n < 200) begin
      @(negedge clk); #1; n++;
    end
    b_resp = axi_bresp;
    b_hold_bad = axi_bvalid ? 0 : 1;
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk); #1;
      if (!axi_bvalid || axi_bresp !== b_resp) b_hold_bad++;
    end
    axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [1:0] bu, input bit toggle,
                         input bit hold);
    int n;
    logic ph, stalled, first;
    logic [31:0] sd;
    logic [1:0] sr;
    logic sl;
    axi_araddr = addr;
    axi_arlen = 8'(len);
    axi_arburst = bu;
    axi_arvalid = 1'b1;
    n = 0;
    #1;
    while (!axi_arready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!axi_arready) begin
      tests_run++; tests_failed++;
      $display("FAIL ar_timeout: arready=0 required 1");
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) axi_arvalid = 1'b0;
    rd_beats = 0; rd_stall_bad = 0; rd_first_ok = 1'b0;
    ph = 1'b0; stalled = 1'b0; first = 1'b1; n = 0;
    sd = '0; sr = '0; sl = 1'b0;
    while (rd_beats <= len && n < 2000) begin
      axi_rready = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      if (first) rd_first_ok = axi_rvalid;
      first = 1'b0;
      if (axi_rvalid) begin
        if (stalled && (axi_rdata !== sd || axi_rresp !== sr ||
                        axi_rlast !== sl))
          rd_stall_bad++;
        if (axi_rready) begin
          rd_d[rd_beats] = axi_rdata;
          rd_r[rd_beats] = axi_rresp;
          rd_l[rd_beats] = axi_rlast;
          rd_beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sd = axi_rdata; sr = axi_rresp; sl = axi_rlast;
        end
      end
      @(negedge clk);
      n++;
    end
    axi_rready = 1'b0;
    rd_after_valid = axi_rvalid;
    if (rd_beats <= len) begin
      tests_run++; tests_failed++;
      $display("FAIL r_timeout: beats=%0d required %0d", rd_beats, len + 1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({axi_awready, axi_arready, axi_wready, axi_bvalid,
         axi_rvalid, axi_rlast} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b required 000000",
               {axi_awready, axi_arready, axi_wready, axi_bvalid,
                axi_rvalid, axi_rlast});
    end
    tests_run++;
    if ({axi_rdata, axi_rresp, axi_bresp} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0",
               axi_rdata, axi_rresp, axi_bresp);
    end
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload;
    for (int i = 0; i < 64; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(32'h0, 63, 2'b01, -1, 1'b0);
    tests_run++;
    if (b_resp !== 2'b00 || w_beats != 64) begin
      tests_failed++;
      $display("FAIL preload: bresp=%b beats=%0d required 00 64",
               b_resp, w_beats);
    end
  endtask

  task automatic test_single;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h10, 0, 2'b01, -1, 1'b0);
    tests_run++;
    if (b_resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_bresp: got %b required 00", b_resp);
    end
    do_read(32'h10, 0, 2'b01, 1'b0, 1'b0);
    tests_run++;
    if (rd_d[0] !== 32'hDEADBEEF || rd_l[0] !== 1'b1 ||
        rd_r[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_read: data=%h last=%b resp=%b required deadbeef 1 00",
               rd_d[0], rd_l[0], rd_r[0]);
    end
    tests_run++;
    if (rd_first_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_latency: rvalid=%b one cycle after AR, required 1",
               rd_first_ok);
    end
  endtask

  task automatic test_incr_burst;
    logic [33:0] e;
    do_read(32'h0, 3, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_rd(32'(4 * i));
      tests_run++;
      if (rd_d[i] !== e[31:0] || rd_r[i] !== e[33:32] ||
          rd_l[i] !== (i == 3)) begin
        tests_failed++;
        $display("FAIL incr_beat%0d: data=%h resp=%b last=%b required %h %b %b",
                 i, rd_d[i], rd_r[i], rd_l[i], e[31:0], e[33:32], i == 3);
      end
    end
    tests_run++;
    if (rd_stall_bad != 0 || rd_after_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL incr_stall: unstable=%0d rvalid_after=%b required 0 0",
               rd_stall_bad, rd_after_valid);
    end
  endtask

  task automatic test_strobe;
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h20, 0, 2'b01, -1, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(32'h20, 0, 2'b01, -1, 1'b0);
    do_read(32'h20, 0, 2'b01, 1'b0, 1'b0);
    tests_run++;
    if (rd_d[0] !== 32'h11BB33DD) begin
      tests_failed++;
      $display("FAIL strobe: got %h required 11bb33dd", rd_d[0]);
    end
  endtask

  task automatic test_oor;
    wd[0] = $urandom; wd[1] = $urandom;
    ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'hFC, 1, 2'b01, -1, 1'b0);
    tests_run++;
    if (b_resp !== 2'b10 || w_beats != 2) begin
      tests_failed++;
      $display("FAIL oor_write: bresp=%b beats=%0d required 10 2",
               b_resp, w_beats);
    end
    do_read(32'hFC, 1, 2'b01, 1'b0, 1'b0);
    tests_run++;
    if (rd_d[0] !== wd[0] || rd_r[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL oor_word63: data=%h resp=%b required %h 00",
               rd_d[0], rd_r[0], wd[0]);
    end
    tests_run++;
    if (rd_d[1] !== 32'h0 || rd_r[1] !== 2'b10 || rd_l[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_beat1: data=%h resp=%b last=%b required 0 10 1",
               rd_d[1], rd_r[1], rd_l[1]);
    end
  endtask

  task automatic test_arbitration;
    logic [33:0] e;
    rst_n = 1'b0;
    axi_awaddr = 32'h40; axi_awlen = 8'd2; axi_awburst = 2'b01;
    axi_araddr = 32'h40; axi_arlen = 8'd0; axi_arburst = 2'b01;
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL arb_grant1: aw,ar=%b required 10",
               {axi_awready, axi_arready});
    end
    do_write(32'h40, 2, 2'b01, 0, 1'b1);
    tests_run++;
    if (b_resp !== 2'b10 || w_beats != 3 || w_extra_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL arb_early_wlast: bresp=%b beats=%0d wready=%b required 10 3 0",
               b_resp, w_beats, w_extra_rdy);
    end
    #1;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL arb_grant2: aw,ar=%b required 01",
               {axi_awready, axi_arready});
    end
    do_read(32'h40, 0, 2'b01, 1'b0, 1'b1);
    e = exp_rd(32'h40);
    tests_run++;
    if (rd_d[0] !== e[31:0]) begin
      tests_failed++;
      $display("FAIL arb_read1: got %h required %h", rd_d[0], e[31:0]);
    end
    #1;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL arb_grant3: aw,ar=%b required 10",
               {axi_awready, axi_arready});
    end
    wd[0] = $urandom; ws[0] = 4'hF;
    do_write(32'h44, 0, 2'b01, -1, 1'b1);
    #1;
    tests_run++;
    if ({axi_awready, axi_arready} !== 2'b01 || b_resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL arb_grant4: aw,ar=%b bresp=%b required 01 00",
               {axi_awready, axi_arready}, b_resp);
    end
    do_read(32'h44, 0, 2'b01, 1'b0, 1'b0);
    axi_awvalid = 1'b0;
    tests_run++;
    if (rd_d[0] !== wd[0]) begin
      tests_failed++;
      $display("FAIL arb_read2: got %h required %h", rd_d[0], wd[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    logic [33:0] e;
    axi_araddr = 32'h0; axi_arlen = 8'd7; axi_arburst = 2'b01;
    axi_arvalid = 1'b1;
    n = 0;
    #1;
    while (!axi_arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    axi_arvalid = 1'b0;
    axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (axi_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_beat2: rvalid=%b required 1", axi_rvalid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({axi_rvalid, axi_rlast, axi_rresp} !== 4'b0 ||
        axi_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: rvalid=%b rlast=%b rresp=%b rdata=%h required 0",
               axi_rvalid, axi_rlast, axi_rresp, axi_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    axi_rready = 1'b0;
    axi_araddr = 32'h80; axi_arlen = 8'd1; axi_arburst = 2'b01;
    axi_arvalid = 1'b1;
    #1;
    tests_run++;
    if (axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_arready: got %b required 1", axi_arready);
    end
    do_read(32'h80, 1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = exp_rd(32'h80 + 32'(4 * i));
      tests_run++;
      if (rd_d[i] !== e[31:0] || rd_l[i] !== (i == 1)) begin
        tests_failed++;
        $display("FAIL mid_read%0d: data=%h last=%b required %h %b",
                 i, rd_d[i], rd_l[i], e[31:0], i == 1);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [1:0] bu, eb;
    logic [33:0] e;
    int len, early;
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 32'h13F));
      len = $urandom_range(0, 7);
      bu = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin
          wd[i] = $urandom;
          ws[i] = 4'($urandom_range(0, 15));
        end
        early = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
        eb = exp_b(a, len, bu, early);
        do_write(a, len, bu, early, 1'b0);
        tests_run++;
        if (b_resp !== eb || w_beats != len + 1 || b_hold_bad != 0) begin
          tests_failed++;
          $display("FAIL rnd_wr%0d: bresp=%b beats=%0d hold=%0d required %b %0d 0",
                   t, b_resp, w_beats, b_hold_bad, eb, len + 1);
        end
      end else begin
        do_read(a, len, bu, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i <= len; i++) begin
          e = exp_rd(beat_addr(a, bu, i));
          tests_run++;
          if (rd_d[i] !== e[31:0] || rd_r[i] !== e[33:32] ||
              rd_l[i] !== (i == len)) begin
            tests_failed++;
            $display("FAIL rnd_rd%0d_%0d: data=%h resp=%b last=%b required %h %b %b",
                     t, i, rd_d[i], rd_r[i], rd_l[i],
                     e[31:0], e[33:32], i == len);
          end
        end
        tests_run++;
        if (rd_stall_bad != 0) begin
          tests_failed++;
          $display("FAIL rnd_stall%0d: unstable=%0d required 0",
                   t, rd_stall_bad);
        end
      end
    end
  endtask

  initial begin
    axi_awvalid = 1'b0; axi_awaddr = '0; axi_awlen = '0;
    axi_awburst = '0; axi_wvalid = 1'b0; axi_wdata = '0;
    axi_wstrb = '0; axi_wlast = 1'b0; axi_bready = 1'b0;
    axi_arvalid = 1'b0; axi_araddr = '0; axi_arlen = '0;
    axi_arburst = '0; axi_rready = 1'b0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_single();
    test_incr_burst();
    test_strobe();
    test_oor();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
